// File: rtl/udp_tx_packet_fifo.sv
// Store-and-forward AXI4-Stream packet FIFO between udp_stream and the 10G MAC TX port.
// Optional macro UDP_TX_FIFO_DROP_CNT_EN adds a saturating drop_count output.
module udp_tx_packet_fifo #(
    parameter int DATA_WIDTH = 64,
    parameter int KEEP_WIDTH = 8,
    parameter int ADDR_WIDTH = 11
) (
    input  logic                  axis_aclk,
    input  logic                  axis_aresetn,
    input  logic [DATA_WIDTH-1:0] s00_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s00_axis_tkeep,
    input  logic                  s00_axis_tlast,
    input  logic                  s00_axis_tuser,
    input  logic                  s00_axis_tvalid,
    output logic                  s00_axis_tready,
    output logic [DATA_WIDTH-1:0] m00_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m00_axis_tkeep,
    output logic                  m00_axis_tlast,
    output logic                  m00_axis_tuser,
    output logic                  m00_axis_tvalid,
    input  logic                  m00_axis_tready,
    output logic [ADDR_WIDTH:0]   pkt_count,
    output logic [ADDR_WIDTH:0]   fill_level
`ifdef UDP_TX_FIFO_DROP_CNT_EN
    ,
    output logic [31:0]           drop_count
`endif
);

    localparam int RAM_W = DATA_WIDTH + KEEP_WIDTH + 1;
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] PTR_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0] FULL_DIST = {1'b1, {ADDR_WIDTH{1'b0}}};

    typedef enum logic [0:0] {ST_ACCEPT = 1'b0, ST_DROP = 1'b1} wr_state_t;

    wr_state_t             r_state;
    logic [ADDR_WIDTH:0]   r_wr_ptr;
    logic [ADDR_WIDTH:0]   r_wr_commit;
    logic [ADDR_WIDTH:0]   r_fetch_ptr;
    logic [ADDR_WIDTH:0]   r_free_ptr;
    logic                  r_s_tready;
    logic [ADDR_WIDTH:0]   r_pkt_count;
    logic [ADDR_WIDTH:0]   r_fill_level;
    logic [RAM_W-1:0]      r_mem [DEPTH];
    logic [RAM_W-1:0]      r_ram_q;
    logic                  r_inflight;
    logic                  r_out_valid;
    logic [RAM_W-1:0]      r_out_word;
    logic                  r_skid_valid;
    logic [RAM_W-1:0]      r_skid_word;

    wr_state_t             w_state_nxt;
    logic [ADDR_WIDTH:0]   w_wr_ptr_nxt;
    logic [ADDR_WIDTH:0]   w_commit_nxt;
    logic [ADDR_WIDTH:0]   w_free_ptr_nxt;
    logic                  w_commit_evt;
    logic                  w_mem_we;
    logic                  w_s_accept;
    logic                  w_pop;
    logic                  w_pop_last;
    logic [1:0]            w_occ;
    logic                  w_fetch;
    logic                  w_full_nxt;
    logic                  w_s_tready_nxt;

    assign w_s_accept     = s00_axis_tvalid & r_s_tready;
    assign w_pop          = r_out_valid & m00_axis_tready;
    assign w_pop_last     = w_pop & r_out_word[0];
    assign w_free_ptr_nxt = w_pop ? (r_free_ptr + PTR_ONE) : r_free_ptr;
    // Beats held in the output pipeline keep their RAM slots until handed to the MAC.
    assign w_occ   = {1'b0, r_out_valid} + {1'b0, r_skid_valid} + {1'b0, r_inflight};
    assign w_fetch = (r_fetch_ptr != r_wr_commit) &&
                     ((w_occ < 2'd2) || ((w_occ == 2'd2) && w_pop));

    // Write FSM next-state, pointer and commit decisions.
    always_comb begin
        w_state_nxt  = r_state;
        w_wr_ptr_nxt = r_wr_ptr;
        w_commit_nxt = r_wr_commit;
        w_commit_evt = 1'b0;
        w_mem_we     = 1'b0;
        case (r_state)
            ST_ACCEPT: begin
                if (w_s_accept) begin
                    w_mem_we = 1'b1;
                    if (s00_axis_tlast && s00_axis_tuser) begin
                        w_wr_ptr_nxt = r_wr_commit;
                    end else if (s00_axis_tlast) begin
                        w_wr_ptr_nxt = r_wr_ptr + PTR_ONE;
                        w_commit_nxt = r_wr_ptr + PTR_ONE;
                        w_commit_evt = 1'b1;
                    end else begin
                        w_wr_ptr_nxt = r_wr_ptr + PTR_ONE;
                    end
                end else begin
                    w_mem_we = 1'b0;
                end
                // A frame that fills the buffer on its own can never complete.
                if (((w_wr_ptr_nxt - w_free_ptr_nxt) == FULL_DIST) &&
                    (w_commit_nxt == w_free_ptr_nxt)) begin
                    w_state_nxt  = ST_DROP;
                    w_wr_ptr_nxt = w_commit_nxt;
                end else begin
                    w_state_nxt = ST_ACCEPT;
                end
            end
            ST_DROP: begin
                if (w_s_accept && s00_axis_tlast) begin
                    w_state_nxt = ST_ACCEPT;
                end else begin
                    w_state_nxt = ST_DROP;
                end
            end
            default: begin
                w_state_nxt = ST_ACCEPT;
            end
        endcase
    end

    assign w_full_nxt     = ((w_wr_ptr_nxt - w_free_ptr_nxt) == FULL_DIST);
    assign w_s_tready_nxt = (w_state_nxt == ST_DROP) | ~w_full_nxt;

    // Write FSM state, pointers and registered status outputs.
    always_ff @(posedge axis_aclk) begin
        if (!axis_aresetn) begin
            r_state      <= ST_ACCEPT;
            r_wr_ptr     <= '0;
            r_wr_commit  <= '0;
            r_s_tready   <= 1'b0;
            r_pkt_count  <= '0;
            r_fill_level <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_wr_ptr     <= w_wr_ptr_nxt;
            r_wr_commit  <= w_commit_nxt;
            r_s_tready   <= w_s_tready_nxt;
            r_fill_level <= w_wr_ptr_nxt - w_free_ptr_nxt;
            case ({w_commit_evt, w_pop_last})
                2'b10:   r_pkt_count <= r_pkt_count + PTR_ONE;
                2'b01:   r_pkt_count <= r_pkt_count - PTR_ONE;
                default: r_pkt_count <= r_pkt_count;
            endcase
        end
    end

    // Simple dual-port storage with registered read.
    always_ff @(posedge axis_aclk) begin
        if (w_mem_we) begin
            r_mem[r_wr_ptr[ADDR_WIDTH-1:0]] <= {s00_axis_tdata, s00_axis_tkeep, s00_axis_tlast};
        end
        if (w_fetch) begin
            r_ram_q <= r_mem[r_fetch_ptr[ADDR_WIDTH-1:0]];
        end
    end

    // Prefetch output register with one-entry skid for full-rate streaming.
    always_ff @(posedge axis_aclk) begin
        if (!axis_aresetn) begin
            r_fetch_ptr  <= '0;
            r_free_ptr   <= '0;
            r_inflight   <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_word   <= '0;
            r_skid_valid <= 1'b0;
            r_skid_word  <= '0;
        end else begin
            r_inflight <= w_fetch;
            r_free_ptr <= w_free_ptr_nxt;
            if (w_fetch) begin
                r_fetch_ptr <= r_fetch_ptr + PTR_ONE;
            end
            if (w_pop || !r_out_valid) begin
                if (r_skid_valid) begin
                    r_out_word   <= r_skid_word;
                    r_out_valid  <= 1'b1;
                    r_skid_valid <= r_inflight;
                    if (r_inflight) begin
                        r_skid_word <= r_ram_q;
                    end
                end else if (r_inflight) begin
                    r_out_word  <= r_ram_q;
                    r_out_valid <= 1'b1;
                end else begin
                    r_out_valid <= 1'b0;
                end
            end else if (r_inflight) begin
                r_skid_word  <= r_ram_q;
                r_skid_valid <= 1'b1;
            end
        end
    end

    assign s00_axis_tready = r_s_tready;
    assign m00_axis_tdata  = r_out_word[RAM_W-1 -: DATA_WIDTH];
    assign m00_axis_tkeep  = r_out_word[KEEP_WIDTH:1];
    assign m00_axis_tlast  = r_out_word[0];
    assign m00_axis_tuser  = 1'b0;
    assign m00_axis_tvalid = r_out_valid;
    assign pkt_count       = r_pkt_count;
    assign fill_level      = r_fill_level;

`ifdef UDP_TX_FIFO_DROP_CNT_EN
    logic        w_drop_evt;
    logic [31:0] r_drop_count;

    // A discard is either a tuser rollback or entry into DROP.
    always_comb begin
        if (r_state == ST_ACCEPT) begin
            w_drop_evt = (w_s_accept && s00_axis_tlast && s00_axis_tuser) ||
                         (w_state_nxt == ST_DROP);
        end else begin
            w_drop_evt = 1'b0;
        end
    end

    // Saturating discarded-frame counter.
    always_ff @(posedge axis_aclk) begin
        if (!axis_aresetn) begin
            r_drop_count <= 32'd0;
        end else if (w_drop_evt && (r_drop_count != 32'hFFFF_FFFF)) begin
            r_drop_count <= r_drop_count + 32'd1;
        end
    end

    assign drop_count = r_drop_count;
`endif

endmodule
